// File: rtl/fp_adder_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready handshake.
// Define FP_ADDER_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate.
module fp_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic [2:0]   flags
);
    localparam int MW   = MAN_W + 4;
    localparam int LZ_W = $clog2(MW + 1);
    localparam int EW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

    localparam logic signed [EW-1:0] EXP_INF_W  = {{(EW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] EXP_ZERO_W = {EW{1'b0}};
    localparam logic signed [EW-1:0] EXP_ONE_W  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [31:0]          ALIGN_MAX  = 32'(MAN_W + 2);

    function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] v);
        logic found;
        found = 1'b0;
        lzc   = LZ_W'(MW);
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                lzc   = LZ_W'(MW - 1 - i);
                found = 1'b1;
            end
        end
    endfunction

    logic             stall_s;
    logic             sign_a_s, sign_b_s, zero_a_s, zero_b_s, inf_a_s, inf_b_s, a_ge_b_s;
    logic             sign_l_s, sign_sm_s, zero_l_s, zero_sm_s, sticky_s;
    logic [EXP_W-1:0] exp_a_s, exp_b_s, exp_l_s, exp_sm_s, diff_s;
    logic [MAN_W-1:0] frac_a_s, frac_b_s, frac_l_s, frac_sm_s;
    logic [MW-1:0]    mant_sm_raw_s;
    logic [31:0]      diff_ext_s;

    logic             s1_sign_d, s1_sub_d, s1_spec_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic [MW-1:0]    s1_mant_l_d, s1_mant_s_d;
    logic [W-1:0]     s1_spec_word_d;
    logic [2:0]       s1_spec_flags_d;

    logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MW-1:0]    s1_mant_l_q, s1_mant_s_q;
    logic [W-1:0]     s1_spec_word_q;
    logic [2:0]       s1_spec_flags_q;

    logic [MW:0]      s2_sum_d;
    logic             s2_valid_q, s2_sign_q, s2_spec_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MW:0]      s2_sum_q;
    logic [W-1:0]     s2_spec_word_q;
    logic [2:0]       s2_spec_flags_q;

    logic [LZ_W-1:0]        lz_s;
    logic signed [EW-1:0]   exp_in_s, lz_w_s, norm_exp_s, exp_r_s;
    logic [MW-1:0]          norm_mant_s;
    logic [MAN_W-1:0]       frac_n_s;
    logic [W-1:0]           sum_d, sum_q;
    logic [2:0]             flags_d, flags_q;
    logic                   out_valid_q;

`ifdef FP_ADDER_ROUND_NEAREST_EN
    logic                   round_inc_s;
    logic [MAN_W+1:0]       rounded_s;
`else
    logic                   grs_unused_s;
    assign grs_unused_s = ^{norm_mant_s[MW-1], norm_mant_s[2:0]};
`endif

    assign stall_s   = out_valid_q & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flags     = flags_q;

    // Stage 1: classify operands, order by magnitude, align the smaller one with sticky collapse
    always_comb begin
        sign_a_s = a[W-1];
        sign_b_s = b[W-1] ^ op;
        exp_a_s  = a[W-2:MAN_W];
        exp_b_s  = b[W-2:MAN_W];
        zero_a_s = (exp_a_s == {EXP_W{1'b0}});
        zero_b_s = (exp_b_s == {EXP_W{1'b0}});
        inf_a_s  = (exp_a_s == {EXP_W{1'b1}});
        inf_b_s  = (exp_b_s == {EXP_W{1'b1}});
        frac_a_s = zero_a_s ? {MAN_W{1'b0}} : a[MAN_W-1:0];
        frac_b_s = zero_b_s ? {MAN_W{1'b0}} : b[MAN_W-1:0];
        a_ge_b_s = ({exp_a_s, frac_a_s} >= {exp_b_s, frac_b_s});
        if (a_ge_b_s) begin
            sign_l_s  = sign_a_s;  exp_l_s  = exp_a_s;  frac_l_s  = frac_a_s;  zero_l_s  = zero_a_s;
            sign_sm_s = sign_b_s;  exp_sm_s = exp_b_s;  frac_sm_s = frac_b_s;  zero_sm_s = zero_b_s;
        end else begin
            sign_l_s  = sign_b_s;  exp_l_s  = exp_b_s;  frac_l_s  = frac_b_s;  zero_l_s  = zero_b_s;
            sign_sm_s = sign_a_s;  exp_sm_s = exp_a_s;  frac_sm_s = frac_a_s;  zero_sm_s = zero_a_s;
        end
        diff_s        = exp_l_s - exp_sm_s;
        diff_ext_s    = {{(32-EXP_W){1'b0}}, diff_s};
        s1_mant_l_d   = {~zero_l_s, frac_l_s, 3'b000};
        mant_sm_raw_s = {~zero_sm_s, frac_sm_s, 3'b000};
        sticky_s      = 1'b0;
        for (int i = 0; i < MW; i++) begin
            sticky_s = sticky_s | (mant_sm_raw_s[i] & (32'(i) < diff_ext_s));
        end
        if (diff_ext_s > ALIGN_MAX) begin
            s1_mant_s_d = {{(MW-1){1'b0}}, |mant_sm_raw_s};
        end else begin
            s1_mant_s_d = (mant_sm_raw_s >> diff_s) | {{(MW-1){1'b0}}, sticky_s};
        end
        s1_sign_d = sign_l_s;
        s1_sub_d  = sign_l_s ^ sign_sm_s;
        s1_exp_d  = exp_l_s;

        // Infinity and double-zero results bypass the arithmetic path
        s1_spec_d       = 1'b1;
        s1_spec_word_d  = {W{1'b0}};
        s1_spec_flags_d = 3'b000;
        if (inf_a_s && inf_b_s) begin
            if (sign_a_s == sign_b_s) begin
                s1_spec_word_d = {sign_a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                s1_spec_flags_d = 3'b001;
            end
        end else if (inf_a_s) begin
            s1_spec_word_d = {sign_a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (inf_b_s) begin
            s1_spec_word_d = {sign_b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a_s && zero_b_s) begin
            s1_spec_word_d  = {sign_a_s & sign_b_s, {(W-1){1'b0}}};
            s1_spec_flags_d = 3'b001;
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    // Stage 2: magnitude add or subtract; L >= S so the difference never goes negative
    always_comb begin
        if (s1_sub_q) begin
            s2_sum_d = {1'b0, s1_mant_l_q} - {1'b0, s1_mant_s_q};
        end else begin
            s2_sum_d = {1'b0, s1_mant_l_q} + {1'b0, s1_mant_s_q};
        end
    end

    // Stage 3: normalise, round, then pick special / zero / overflow / underflow / normal result
    always_comb begin
        exp_in_s = {{(EW-EXP_W){1'b0}}, s2_exp_q};
        lz_s     = lzc(s2_sum_q[MW-1:0]);
        lz_w_s   = {{(EW-LZ_W){1'b0}}, lz_s};
        if (s2_sum_q[MW]) begin
            norm_mant_s = {s2_sum_q[MW:2], s2_sum_q[1] | s2_sum_q[0]};
            norm_exp_s  = exp_in_s + EXP_ONE_W;
        end else begin
            norm_mant_s = s2_sum_q[MW-1:0] << lz_s;
            norm_exp_s  = exp_in_s - lz_w_s;
        end
`ifdef FP_ADDER_ROUND_NEAREST_EN
        round_inc_s = norm_mant_s[2] & (norm_mant_s[1] | norm_mant_s[0] | norm_mant_s[3]);
        rounded_s   = {1'b0, norm_mant_s[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_inc_s};
        if (rounded_s[MAN_W+1]) begin
            frac_n_s = rounded_s[MAN_W:1];
            exp_r_s  = norm_exp_s + EXP_ONE_W;
        end else begin
            frac_n_s = rounded_s[MAN_W-1:0];
            exp_r_s  = norm_exp_s;
        end
`else
        frac_n_s = norm_mant_s[MW-2:3];
        exp_r_s  = norm_exp_s;
`endif
        if (!s2_valid_q) begin
            sum_d   = {W{1'b0}};
            flags_d = 3'b000;
        end else if (s2_spec_q) begin
            sum_d   = s2_spec_word_q;
            flags_d = s2_spec_flags_q;
        end else if (s2_sum_q == {(MW+1){1'b0}}) begin
            sum_d   = {W{1'b0}};
            flags_d = 3'b001;
        end else if (exp_r_s >= EXP_INF_W) begin
            sum_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 3'b100;
        end else if (exp_r_s <= EXP_ZERO_W) begin
            sum_d   = {s2_sign_q, {(W-1){1'b0}}};
            flags_d = 3'b010;
        end else begin
            sum_d   = {s2_sign_q, exp_r_s[EXP_W-1:0], frac_n_s};
            flags_d = 3'b000;
        end
    end

    // Pipeline registers: every stage advances together and holds as a whole under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_sub_q        <= 1'b0;
            s1_spec_q       <= 1'b0;
            s1_exp_q        <= {EXP_W{1'b0}};
            s1_mant_l_q     <= {MW{1'b0}};
            s1_mant_s_q     <= {MW{1'b0}};
            s1_spec_word_q  <= {W{1'b0}};
            s1_spec_flags_q <= 3'b000;
            s2_valid_q      <= 1'b0;
            s2_sign_q       <= 1'b0;
            s2_spec_q       <= 1'b0;
            s2_exp_q        <= {EXP_W{1'b0}};
            s2_sum_q        <= {(MW+1){1'b0}};
            s2_spec_word_q  <= {W{1'b0}};
            s2_spec_flags_q <= 3'b000;
            out_valid_q     <= 1'b0;
            sum_q           <= {W{1'b0}};
            flags_q         <= 3'b000;
        end else if (!stall_s) begin
            s1_valid_q      <= in_valid;
            s1_sign_q       <= s1_sign_d;
            s1_sub_q        <= s1_sub_d;
            s1_spec_q       <= s1_spec_d;
            s1_exp_q        <= s1_exp_d;
            s1_mant_l_q     <= s1_mant_l_d;
            s1_mant_s_q     <= s1_mant_s_d;
            s1_spec_word_q  <= s1_spec_word_d;
            s1_spec_flags_q <= s1_spec_flags_d;
            s2_valid_q      <= s1_valid_q;
            s2_sign_q       <= s1_sign_q;
            s2_spec_q       <= s1_spec_q;
            s2_exp_q        <= s1_exp_q;
            s2_sum_q        <= s2_sum_d;
            s2_spec_word_q  <= s1_spec_word_q;
            s2_spec_flags_q <= s1_spec_flags_q;
            out_valid_q     <= s2_valid_q;
            sum_q           <= sum_d;
            flags_q         <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed self-checking bench for fp_adder_pipe (single precision), covering both rounding builds.
module tb_fp_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic [2:0]  flags;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .flags(flags)
    );

    // Single transaction with out_ready high; lat counts cycles from acceptance to out_valid
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                          output logic [31:0] rs, output logic [2:0] rf, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rs = sum;
        rf = flags;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || flags !== 3'b000) begin
            $display("FAIL reset_state: out_valid=%b sum=%h flags=%b required 0/00000000/000", out_valid, sum, flags);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
            fails++;
        end
    endtask

    task automatic test_add();
        logic [31:0] va [3] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000};
        logic [31:0] vb [3] = '{32'h40000000, 32'h40400000, 32'h3F800000};
        logic        vo [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ws [3] = '{32'h40400000, 32'hC0000000, 32'h40200000};
        logic [31:0] rs;
        logic [2:0]  rf;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vo[i], rs, rf, lat);
            checks++;
            if (rs !== ws[i] || rf !== 3'b000) begin
                $display("FAIL add_%0d: sum=%h flags=%b required %h/000", i, rs, rf, ws[i]);
                fails++;
            end
            checks++;
            if (lat !== 3) begin
                $display("FAIL latency_%0d: got %0d cycles required 3", i, lat);
                fails++;
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [8] = '{32'h40400000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000,
                               32'h00000000, 32'h80000000, 32'h7F800000, 32'h00C00000};
        logic [31:0] vb [8] = '{32'h40400000, 32'hBF800000, 32'h7F7FFFFF, 32'h3F800000,
                               32'h3F800000, 32'h80000000, 32'h7F800000, 32'h00800000};
        logic        vo [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ws [8] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                               32'h3F800000, 32'h80000000, 32'h00000000, 32'h00000000};
        logic [2:0]  wf [8] = '{3'b001, 3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
        string       nm [8] = '{"cancel_sub", "cancel_add", "overflow", "inf_plus_one",
                               "zero_plus_one", "negzero_sum", "inf_minus_inf", "underflow"};
        logic [31:0] rs;
        logic [2:0]  rf;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vo[i], rs, rf, lat);
            checks++;
            if (rs !== ws[i] || rf !== wf[i]) begin
                $display("FAIL %s: sum=%h flags=%b required %h/%b", nm[i], rs, rf, ws[i], wf[i]);
                fails++;
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] rs;
        logic [2:0]  rf;
        logic [31:0] want;
        int          lat;
`ifdef FP_ADDER_ROUND_NEAREST_EN
        want = 32'h3F800002;
`else
        want = 32'h3F800001;
`endif
        run_op(32'h3F800001, 32'h33800000, 1'b0, rs, rf, lat);
        checks++;
        if (rs !== want || rf !== 3'b000) begin
            $display("FAIL rounding: sum=%h flags=%b required %h/000", rs, rf, want);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [5] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h40800000};
        logic [31:0] vb [5] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F000000};
        logic        vo [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ws [5] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h40200000, 32'h40600000};
        logic [31:0] got [5];
        logic [31:0] held;
        logic        drv_ok, seen, prev_rdy, stable;
        int          n, first, last;
        @(negedge clk);
        out_ready = 1'b0;
        drv_ok = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic acc;
                    int   tries;
                    acc = 1'b0;
                    tries = 0;
                    while (!acc && tries < 50) begin
                        @(negedge clk);
                        a = va[i]; b = vb[i]; op = vo[i]; in_valid = 1'b1;
                        #1 acc = in_ready;
                        @(posedge clk);
                        tries++;
                    end
                    if (!acc) drv_ok = 1'b0;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                prev_rdy = 1'b0;
                n = 0;
                while (!seen && n < 30) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                    else begin
                        prev_rdy = in_ready;
                        n++;
                    end
                end
                checks++;
                if (!seen || prev_rdy !== 1'b1 || in_ready !== 1'b0) begin
                    $display("FAIL stall_in_ready: seen=%b in_ready before=%b after=%b required 1/1/0", seen, prev_rdy, in_ready);
                    fails++;
                end
                held = sum;
                stable = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (sum !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
                end
                checks++;
                if (!stable || held !== ws[0]) begin
                    $display("FAIL stall_hold: stable=%b sum=%h required 1/%h", stable, held, ws[0]);
                    fails++;
                end
                out_ready = 1'b1;
                n = 0; first = -1; last = -1;
                for (int c = 0; c < 10; c++) begin
                    if (c > 0) @(negedge clk);
                    if (out_valid) begin
                        if (n < 5) got[n] = sum;
                        if (n == 0) first = c;
                        last = c;
                        n++;
                    end
                end
                checks++;
                if (n !== 5 || last - first !== 4) begin
                    $display("FAIL drain_count: results=%0d span=%0d required 5/4", n, last - first);
                    fails++;
                end
                for (int i = 0; i < 5 && i < n; i++) begin
                    checks++;
                    if (got[i] !== ws[i]) begin
                        $display("FAIL drain_order_%0d: sum=%h required %h", i, got[i], ws[i]);
                        fails++;
                    end
                end
            end
        join
        checks++;
        if (drv_ok !== 1'b1) begin
            $display("FAIL drive_accept: driver timed out (ok=%b required 1)", drv_ok);
            fails++;
        end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] rs;
        logic [2:0]  rf;
        int          lat, stale;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h40000000; b = 32'h40000000;
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h3F800000;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h40000000) begin
            $display("FAIL pre_reset_result: out_valid=%b sum=%h required 1/40000000", out_valid, sum);
            fails++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || flags !== 3'b000) begin
            $display("FAIL async_reset: out_valid=%b sum=%h flags=%b required 0/00000000/000", out_valid, sum, flags);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            $display("FAIL stale_after_reset: %0d stale results required 0", stale);
            fails++;
        end
        run_op(32'h40000000, 32'h3F800000, 1'b0, rs, rf, lat);
        checks++;
        if (rs !== 32'h40400000 || rf !== 3'b000 || lat !== 3) begin
            $display("FAIL post_reset_op: sum=%h flags=%b lat=%0d required 40400000/000/3", rs, rf, lat);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_special();
        test_rounding();
        test_back_to_back();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
